seg595_scan_ctrl: RTL and testbench

SEG595_SCAN_CTRL -- requirements
Module: seg595_scan_ctrl

---
 rtl/seg595_pkg.sv | 32 +++
 rtl/seg595_scan_ctrl_shifter.sv | 78 +++++++
 rtl/seg595_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seg595_scan_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg595_pkg.sv
// Shared constants, scan state type and frame builder for the 74HC595 seven-segment scanner.
package seg595_pkg;

    localparam int unsigned FRAME_W    = 16;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned DIGIT_W    = 2;
    localparam int unsigned SNAP_W     = NUM_DIGITS * SEG_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DWELL
    } scan_state_t;

    // Frame is {segment byte, one-hot digit select}; blanking clears both halves.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [SNAP_W-1:0]  snap,
        input logic [DIGIT_W-1:0] digit,
        input logic               blank
    );
        logic [SEG_W-1:0] sel;
        sel = 8'h01 << digit;
        if (blank) begin
            return '0;
        end
        return {snap[{digit, 3'b000} +: SEG_W], sel};
    endfunction

endpackage

// File: rtl/seg595_scan_ctrl_shifter.sv
// 16-bit serializer for a 74HC595 chain; ser_clk low then high for CLK_DIV cycles per bit.
// Optional SEG595_MSB_FIRST_EN: emit frame bit 15 first instead of bit 0.
module hc595_shifter
    import seg595_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic               s_clk,
    input  logic               s_reset_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               done_c,
    output logic               ser_data,
    output logic               ser_clk
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = $clog2(FRAME_W);

`ifdef SEG595_MSB_FIRST_EN
    localparam int unsigned OUT_BIT = FRAME_W - 1;
    function automatic logic [FRAME_W-1:0] advance(input logic [FRAME_W-1:0] v);
        return v << 1;
    endfunction
`else
    localparam int unsigned OUT_BIT = 0;
    function automatic logic [FRAME_W-1:0] advance(input logic [FRAME_W-1:0] v);
        return v >> 1;
    endfunction
`endif

    logic               active;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic               div_end_c;

    assign div_end_c = (div_cnt == DIV_W'(CLK_DIV - 1));
    // Last high phase of the last bit: the owner moves on at this edge.
    assign done_c    = active && ser_clk && div_end_c && (bit_cnt == BIT_W'(FRAME_W - 1));

    always_ff @(posedge s_clk) begin
        if (!s_reset_n) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ser_data <= 1'b0;
            ser_clk  <= 1'b0;
        end else if (start) begin
            active   <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= advance(frame);
            ser_data <= frame[OUT_BIT];
            ser_clk  <= 1'b0;
        end else if (active) begin
            if (div_end_c) begin
                div_cnt <= '0;
                if (!ser_clk) begin
                    ser_clk <= 1'b1;
                end else begin
                    ser_clk <= 1'b0;
                    if (bit_cnt == BIT_W'(FRAME_W - 1)) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt  <= bit_cnt + BIT_W'(1);
                        ser_data <= shreg[OUT_BIT];
                        shreg    <= advance(shreg);
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/seg595_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner driving a 74HC595 chain.
// Optional SEG595_MSB_FIRST_EN (in hc595_shifter): frame bit 15 shifted first.
module seg595_scan_ctrl
    import seg595_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DWELL   = 1000
) (
    input  logic              s_clk,
    input  logic              s_reset_n,
    input  logic [SNAP_W-1:0] seg_data,
    input  logic              update_req,
    output logic              update_ack,
    input  logic              blank,
    output logic              ser_data,
    output logic              ser_clk,
    output logic              ser_latch,
    output logic [1:0]        scan_digit,
    output logic              busy
);

    localparam int unsigned DWELL_W = 16;

    scan_state_t        state, state_next;
    logic [1:0]         digit_next;
    logic [SNAP_W-1:0]  snapshot, snap_next;
    logic [FRAME_W-1:0] frame, frame_next;
    logic [DWELL_W-1:0] dwell_cnt, dwell_next;
    logic               ack_next, latch_next, busy_next;
    logic               start_c, load_c, shift_done_c;

    hc595_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .s_clk     (s_clk),
        .s_reset_n (s_reset_n),
        .start     (start_c),
        .frame     (frame),
        .done_c    (shift_done_c),
        .ser_data  (ser_data),
        .ser_clk   (ser_clk)
    );

    always_ff @(posedge s_clk) begin
        if (!s_reset_n) begin
            state      <= ST_IDLE;
            scan_digit <= '0;
            snapshot   <= '0;
            frame      <= '0;
            dwell_cnt  <= '0;
            update_ack <= 1'b0;
            ser_latch  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            scan_digit <= digit_next;
            snapshot   <= snap_next;
            frame      <= frame_next;
            dwell_cnt  <= dwell_next;
            update_ack <= ack_next;
            ser_latch  <= latch_next;
            busy       <= busy_next;
        end
    end

    // Frame and snapshot are prepared on the edge entering LOAD so LOAD can start the shift.
    always_comb begin
        state_next = state;
        digit_next = scan_digit;
        snap_next  = snapshot;
        frame_next = frame;
        dwell_next = dwell_cnt;
        ack_next   = 1'b0;
        latch_next = 1'b0;
        start_c    = 1'b0;
        load_c     = 1'b0;

        case (state)
            ST_IDLE: begin
                state_next = ST_LOAD;
                digit_next = '0;
                load_c     = 1'b1;
            end
            ST_LOAD: begin
                start_c    = 1'b1;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shift_done_c) begin
                    state_next = ST_LATCH;
                    latch_next = 1'b1;
                end
            end
            ST_LATCH: begin
                state_next = ST_DWELL;
                dwell_next = '0;
            end
            ST_DWELL: begin
                if (dwell_cnt == DWELL_W'(DWELL - 1)) begin
                    state_next = ST_LOAD;
                    digit_next = scan_digit + 2'd1;
                    load_c     = 1'b1;
                end else begin
                    dwell_next = dwell_cnt + DWELL_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (load_c) begin
            if ((digit_next == 2'd0) && update_req) begin
                snap_next = seg_data;
                ack_next  = 1'b1;
            end
            frame_next = build_frame(snap_next, digit_next, blank);
        end

        busy_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_seg595_scan_ctrl.sv
// Randomized bench for seg595_scan_ctrl against a cycle-position reference model.
module tb_seg595_scan_ctrl;

    localparam int CD        = 2;
    localparam int DW        = 10;
    localparam int SHIFT_LEN = 32 * CD;
    localparam int P         = 2 + SHIFT_LEN + DW;

    logic        s_clk = 1'b0;
    logic        s_reset_n;
    logic [31:0] seg_data;
    logic        update_req;
    logic        update_ack;
    logic        blank;
    logic        ser_data;
    logic        ser_clk;
    logic        ser_latch;
    logic [1:0]  scan_digit;
    logic        busy;

    seg595_scan_ctrl #(
        .CLK_DIV (CD),
        .DWELL   (DW)
    ) dut (
        .s_clk      (s_clk),
        .s_reset_n  (s_reset_n),
        .seg_data   (seg_data),
        .update_req (update_req),
        .update_ack (update_ack),
        .blank      (blank),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .ser_latch  (ser_latch),
        .scan_digit (scan_digit),
        .busy       (busy)
    );

    always #5 s_clk = ~s_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the per-digit period after reset release.
    int          m_c    = 0;
    int          m_p    = 0;
    int          m_d    = 0;
    logic [31:0] m_snap = '0;
    logic [15:0] m_frame = '0;
    logic        m_ack  = 1'b0;

    logic [15:0] cap         = '0;
    int          ncap        = 0;
    logic        prev_clk    = 1'b0;
    int          last_latch_c = -1;
    int          first_ack_c  = -1;
    int          acks         = 0;
    logic [15:0] seen [4];
    logic        req_q = 1'b0;
    logic        blk_q = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, m_c);
        end
    endtask

    task automatic model_edge(input logic rst, input logic req, input logic [31:0] sd, input logic blk);
        logic [7:0] sel;
        if (!rst) begin
            m_c = 0; m_p = 0; m_d = 0;
            m_snap = '0; m_frame = '0; m_ack = 1'b0;
        end else begin
            m_c++;
            m_ack = 1'b0;
            m_p = (m_c - 1) % P;
            m_d = ((m_c - 1) / P) % 4;
            if (m_p == 0) begin
                if (m_d == 0 && req) begin
                    m_ack  = 1'b1;
                    m_snap = sd;
                end
                sel = 8'h01 << m_d;
                m_frame = blk ? 16'h0000 : {m_snap[8*m_d +: 8], sel};
            end
        end
    endtask

    task automatic check_cycle();
        logic       in_shift, e_clk, e_data, mask, e_latch;
        logic [1:0] e_dig;
        logic [6:0] got, exp;
        int         s, idx, pos;
        in_shift = (m_c >= 1) && (m_p >= 1) && (m_p <= SHIFT_LEN);
        s        = m_p - 1;
        e_clk    = 1'b0;
        e_data   = 1'b0;
        if (in_shift) begin
            e_clk = (s % (2 * CD)) >= CD;
            idx   = s / (2 * CD);
`ifdef SEG595_MSB_FIRST_EN
            idx = 15 - idx;
`endif
            e_data = m_frame[idx];
        end
        mask    = in_shift || (m_c == 0);
        e_dig   = (m_c >= 1) ? 2'(m_d) : 2'd0;
        e_latch = (m_c >= 1) && (m_p == SHIFT_LEN + 1);
        exp = {m_c >= 1, e_dig, m_ack, e_latch, e_clk, e_data & mask};
        got = {busy, scan_digit, update_ack, ser_latch, ser_clk, ser_data & mask};
        check_eq("outputs", 32'(got), 32'(exp));

        if (m_c == 0) begin
            ncap = 0; cap = '0; prev_clk = 1'b0; last_latch_c = -1;
        end else begin
            if (ser_clk && !prev_clk) begin
                if (ncap < 16) begin
`ifdef SEG595_MSB_FIRST_EN
                    pos = 15 - ncap;
`else
                    pos = ncap;
`endif
                    cap[pos] = ser_data;
                end
                ncap++;
            end
            prev_clk = ser_clk;
            if (ser_latch) begin
                check_eq("bit_count", 32'(ncap), 32'd16);
                check_eq("frame", 32'(cap), 32'(m_frame));
                seen[m_d] = cap;
                if (last_latch_c >= 0)
                    check_eq("latch_gap", 32'(m_c - last_latch_c), 32'(P));
                last_latch_c = m_c;
                ncap = 0;
                cap  = '0;
            end
            if (update_ack) begin
                acks++;
                if (first_ack_c < 0) first_ack_c = m_c;
                check_eq("ack_digit", 32'(scan_digit), 32'd0);
            end
        end
    endtask

    task automatic step(input logic rst, input logic req, input logic [31:0] sd, input logic blk);
        s_reset_n  = rst;
        update_req = req;
        seg_data   = sd;
        blank      = blk;
        model_edge(rst, req, sd, blk);
        @(posedge s_clk);
        @(negedge s_clk);
        check_cycle();
    endtask

    initial begin
        int a0;
        int bstate;
        logic raised;
        s_reset_n = 1'b0; update_req = 1'b1; seg_data = 32'h4F5B067F; blank = 1'b0;
        for (int k = 0; k < 4; k++) seen[k] = 16'hFFFF;

        // Reset with a pending request, then four digits of known data.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h4F5B067F, 1'b0);
        req_q = 1'b1;
        for (int i = 0; i < 4 * P + 2; i++) begin
            step(1'b1, req_q, 32'h4F5B067F, 1'b0);
            if (m_ack) req_q = 1'b0;
        end
        check_eq("first_ack_c", 32'(first_ack_c), 32'd1);
        check_eq("d0_frame", 32'(seen[0]), 32'h7F01);
        check_eq("d1_frame", 32'(seen[1]), 32'h0602);
        check_eq("d2_frame", 32'(seen[2]), 32'h5B04);
        check_eq("d3_frame", 32'(seen[3]), 32'h4F08);

        // Request raised during digit 2 must wait for the next digit-0 load.
        raised = 1'b0;
        a0 = acks;
        for (int i = 0; i < 4 * P + 10; i++) begin
            if (!raised && m_d == 2 && m_p == 10) begin
                req_q = 1'b1;
                raised = 1'b1;
            end
            step(1'b1, req_q, $urandom, 1'b0);
            if (m_ack) req_q = 1'b0;
        end
        check_eq("ack_deferred", 32'(acks - a0), 32'd1);

        // Blank asserted during digit 1 dwell blanks digit 2 only.
        bstate = 0;
        seen[2] = 16'hFFFF;
        seen[3] = 16'hFFFF;
        for (int i = 0; i < 5 * P; i++) begin
            if (bstate == 0 && m_d == 1 && m_p > SHIFT_LEN + 1) begin
                blk_q = 1'b1; bstate = 1;
            end else if (bstate == 1 && m_d == 2 && m_p >= 1) begin
                blk_q = 1'b0; bstate = 2;
            end
            step(1'b1, 1'b0, $urandom, blk_q);
            if (bstate == 2 && m_d == 3 && m_p == SHIFT_LEN + 2) break;
        end
        check_eq("blank_frame", 32'(seen[2]), 32'h0000);
        check_eq("resume_frame", 32'(seen[3]), 32'({m_snap[31:24], 8'h08}));

        // Random requests, blanking and seg_data churn.
        for (int i = 0; i < 6 * P; i++) begin
            if (!req_q && $urandom_range(0, 149) == 0) req_q = 1'b1;
            if ($urandom_range(0, 119) == 0) blk_q = ~blk_q;
            step(1'b1, req_q, $urandom, blk_q);
            if (m_ack) req_q = 1'b0;
        end

        // One-cycle reset in the middle of a shift.
        req_q = 1'b0;
        blk_q = 1'b0;
        for (int i = 0; i < P && !(m_c >= 1 && m_p == 20); i++) step(1'b1, 1'b0, $urandom, 1'b0);
        step(1'b0, 1'b0, $urandom, 1'b0);
        check_eq("rst_outputs", 32'({busy, scan_digit, update_ack, ser_latch, ser_clk, ser_data}), 32'd0);
        seen[0] = 16'hFFFF;
        for (int i = 0; i < P; i++) step(1'b1, 1'b0, $urandom, 1'b0);
        check_eq("rst_frame", 32'(seen[0]), 32'h0001);

        for (int i = 0; i < 2 * P; i++) begin
            if (!req_q && $urandom_range(0, 49) == 0) req_q = 1'b1;
            step(1'b1, req_q, $urandom, 1'b0);
            if (m_ack) req_q = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
